// File: rtl/n64_flash_sequencer_if.sv
// Bus bundle between the CPU command registers, the sequencer and the
// bootloader's CPU-side flash port.
interface n64_flash_sequencer_if;
    // CPU command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_sector;
    logic [31:0] cmd_address;
    logic [31:0] cmd_wdata;
    logic        done;
    logic [1:0]  result;
    logic [31:0] rdata;
    // Flash port side
    logic        flash_request;
    logic        flash_write;
    logic [31:0] flash_address;
    logic [31:0] flash_wdata;
    logic [31:0] flash_rdata;
    logic        flash_ack;

    // Sequencer view
    modport master (
        input  cmd_valid, cmd_op, cmd_sector, cmd_address, cmd_wdata,
        input  flash_rdata, flash_ack,
        output cmd_ready, done, result, rdata,
        output flash_request, flash_write, flash_address, flash_wdata
    );

    // CPU / flash-port view
    modport slave (
        output cmd_valid, cmd_op, cmd_sector, cmd_address, cmd_wdata,
        output flash_rdata, flash_ack,
        input  cmd_ready, done, result, rdata,
        input  flash_request, flash_write, flash_address, flash_wdata
    );
endinterface

// File: rtl/n64_flash_sequencer.sv
// UFM erase/program/read sequencer: unprotect -> operate -> poll -> re-protect,
// one flash transaction outstanding, one done pulse per accepted command.
module n64_flash_sequencer #(
    parameter logic [31:0] CSR_BASE     = 32'h0800_0000,
    parameter logic [23:0] POLL_TIMEOUT = 24'd8_000_000
) (
    input logic                       clk_i,
    input logic                       rst_i,
    n64_flash_sequencer_if.master     bus_if
);

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_ERASE   = 2'd2;

    localparam logic [1:0] RES_OK      = 2'd0;
    localparam logic [1:0] RES_BAD_CMD = 2'd1;
    localparam logic [1:0] RES_TIMEOUT = 2'd2;
    localparam logic [1:0] RES_FAIL    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_UNPROT  = 3'd2,
        S_PROGRAM = 3'd3,
        S_POLL    = 3'd4,
        S_PROTECT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Control register layout: write-protect mask per sector plus erase-sector field.
    function automatic logic [31:0] ctrl_word(input logic [4:0] wp, input logic [2:0] sec);
        return {4'hF, wp, sec, 20'hFFFFF};
    endfunction

    // Reserved opcode, or a sector outside 1..5 for a sector-based op.
    function automatic logic cmd_is_bad(input logic [1:0] op, input logic [2:0] sec);
        return (op == 2'd3) || ((op != OP_READ) && ((sec == 3'd0) || (sec > 3'd5)));
    endfunction

    // Success flag in the status word depends on which operation ran.
    function automatic logic op_succeeded(input logic [1:0] op, input logic [31:0] status);
        return (op == OP_PROGRAM) ? status[3] : status[4];
    endfunction

    state_t      state_q,  state_d;
    logic [1:0]  op_q,     op_d;
    logic [2:0]  sector_q, sector_d;
    logic [31:0] caddr_q,  caddr_d;
    logic [31:0] cwdata_q, cwdata_d;
    logic        req_q,    req_d;
    logic        fwrite_q, fwrite_d;
    logic [31:0] faddr_q,  faddr_d;
    logic [31:0] fwdata_q, fwdata_d;
    logic        done_q,   done_d;
    logic [1:0]  result_q, result_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [23:0] cnt_q,    cnt_d;

    logic [31:0] unprot_s;
    logic [31:0] prot_s;

    assign prot_s   = ctrl_word(5'h1F, 3'h7);
    assign unprot_s = ctrl_word(5'h1F & ~(5'd1 << (sector_q - 3'd1)),
                                (op_q == OP_ERASE) ? sector_q : 3'h7);

    assign bus_if.cmd_ready     = (state_q == S_IDLE);
    assign bus_if.done          = done_q;
    assign bus_if.result        = result_q;
    assign bus_if.rdata         = rdata_q;
    assign bus_if.flash_request = req_q;
    assign bus_if.flash_write   = fwrite_q;
    assign bus_if.flash_address = faddr_q;
    assign bus_if.flash_wdata   = fwdata_q;

    // Next-state and output logic; a flash state raises its request the cycle after entry
    // (or after the previous ack) and leaves on its ack.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sector_d = sector_q;
        caddr_d  = caddr_q;
        cwdata_d = cwdata_q;
        req_d    = req_q;
        fwrite_d = fwrite_q;
        faddr_d  = faddr_q;
        fwdata_d = fwdata_q;
        done_d   = 1'b0;
        result_d = result_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus_if.cmd_valid) begin
                    op_d     = bus_if.cmd_op;
                    sector_d = bus_if.cmd_sector;
                    caddr_d  = bus_if.cmd_address;
                    cwdata_d = bus_if.cmd_wdata;
                    result_d = RES_OK;
                    if (cmd_is_bad(bus_if.cmd_op, bus_if.cmd_sector)) begin
                        result_d = RES_BAD_CMD;
                        state_d  = S_DONE;
                    end else if (bus_if.cmd_op == OP_READ) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_UNPROT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_READ: begin
                if (!req_q) begin
                    req_d    = 1'b1;
                    fwrite_d = 1'b0;
                    faddr_d  = caddr_q;
                end else if (bus_if.flash_ack) begin
                    req_d    = 1'b0;
                    rdata_d  = bus_if.flash_rdata;
                    result_d = RES_OK;
                    state_d  = S_DONE;
                end else begin
                    req_d = 1'b1;
                end
            end

            S_UNPROT: begin
                if (!req_q) begin
                    req_d    = 1'b1;
                    fwrite_d = 1'b1;
                    faddr_d  = CSR_BASE + 32'd4;
                    fwdata_d = unprot_s;
                end else if (bus_if.flash_ack) begin
                    req_d = 1'b0;
                    cnt_d = 24'd0;
                    if (op_q == OP_PROGRAM) begin
                        state_d = S_PROGRAM;
                    end else begin
                        state_d = S_POLL;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end

            S_PROGRAM: begin
                if (!req_q) begin
                    req_d    = 1'b1;
                    fwrite_d = 1'b1;
                    faddr_d  = caddr_q;
                    fwdata_d = cwdata_q;
                end else if (bus_if.flash_ack) begin
                    req_d   = 1'b0;
                    cnt_d   = 24'd0;
                    state_d = S_POLL;
                end else begin
                    req_d = 1'b1;
                end
            end

            S_POLL: begin
                // Saturating timeout counter; only the next ack may act on it.
                if (cnt_q != POLL_TIMEOUT) begin
                    cnt_d = cnt_q + 24'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                if (!req_q) begin
                    req_d    = 1'b1;
                    fwrite_d = 1'b0;
                    faddr_d  = CSR_BASE;
                end else if (bus_if.flash_ack) begin
                    req_d = 1'b0;
                    if (bus_if.flash_rdata[1:0] == 2'b00) begin
                        result_d = op_succeeded(op_q, bus_if.flash_rdata) ? RES_OK : RES_FAIL;
                        state_d  = S_PROTECT;
                    end else if (cnt_q == POLL_TIMEOUT) begin
                        result_d = RES_TIMEOUT;
                        state_d  = S_PROTECT;
                    end else begin
                        state_d = S_POLL;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end

            S_PROTECT: begin
                if (!req_q) begin
                    req_d    = 1'b1;
                    fwrite_d = 1'b1;
                    faddr_d  = CSR_BASE + 32'd4;
                    fwdata_d = prot_s;
                end else if (bus_if.flash_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    req_d = 1'b1;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            sector_q <= 3'd0;
            caddr_q  <= 32'd0;
            cwdata_q <= 32'd0;
            req_q    <= 1'b0;
            fwrite_q <= 1'b0;
            faddr_q  <= 32'd0;
            fwdata_q <= 32'd0;
            done_q   <= 1'b0;
            result_q <= 2'd0;
            rdata_q  <= 32'd0;
            cnt_q    <= 24'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sector_q <= sector_d;
            caddr_q  <= caddr_d;
            cwdata_q <= cwdata_d;
            req_q    <= req_d;
            fwrite_q <= fwrite_d;
            faddr_q  <= faddr_d;
            fwdata_q <= fwdata_d;
            done_q   <= done_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
